alu_arbiter: RTL

//  Shares one registered ALU between two requesters (req0 = integer pipe, req1 = branch/compare unit).

---
 rtl/alu_arb_pkg.sv | 21 ++
 rtl/alu_arbiter_if.sv | 28 ++
 rtl/alu_arb_grant.sv | 21 ++
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// State encoding, accepted ALU opcodes and the error-response constants.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StResp = 2'b10
    } state_e;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    localparam logic ERR_FLAG = 1'b1;
    localparam logic ERR_ZF   = 1'b1;

    function automatic logic is_alu_op(input logic [31:0] inst);
        return (inst[6:0] == OPC_R) || (inst[6:0] == OPC_I);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester channel of the ALU arbiter: request (valid/ready + operands)
// and the matching response (valid/ready + result, zero flag, error).
interface alu_arbiter_if #(
    parameter int unsigned N = 32
) ();

    logic          req_valid;
    logic          req_ready;
    logic [N-1:0]  req_rs1;
    logic [N-1:0]  req_rs2;
    logic [31:0]   req_inst;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_res;
    logic          rsp_zf;
    logic          rsp_err;

    modport master (
        output req_valid, req_rs1, req_rs2, req_inst, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_zf, rsp_err
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_inst, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_zf, rsp_err
    );

endinterface

// File: rtl/alu_arb_grant.sv
// Combinational two-way grant. ALU_ARB_RR_EN selects round-robin on ties;
// otherwise requester 0 has fixed priority.
module alu_arb_grant (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic any_o,
    output logic grant_o
);

    assign any_o = valid0_i | valid1_i;

`ifdef ALU_ARB_RR_EN
    assign grant_o = (valid0_i & valid1_i) ? ~last_grant_i : valid1_i;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign grant_o = ~valid0_i & valid1_i;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters, one op in flight at a time.
// Grant policy is selected by the ALU_ARB_RR_EN macro (see alu_arb_grant).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_arbiter_if.slave    ch0,
    alu_arbiter_if.slave    ch1,
    output logic [N-1:0]    alu_rs1,
    output logic [N-1:0]    alu_rs2,
    output logic [31:0]     alu_inst,
    input  logic [N-1:0]    alu_res,
    input  logic            alu_zf
);

    localparam int unsigned CntW = $clog2(ALU_LAT + 1);

    state_e               state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic                 last_q, last_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [N-1:0]         alu_rs1_q, alu_rs1_d;
    logic [N-1:0]         alu_rs2_q, alu_rs2_d;
    logic [31:0]          alu_inst_q, alu_inst_d;
    logic [1:0][N-1:0]    res_q, res_d;
    logic [1:0]           zf_q, zf_d;
    logic [1:0]           err_q, err_d;
    logic [1:0]           req_ready;

    logic                 any_req;
    logic                 gnt_sel;
    logic [N-1:0]         sel_rs1;
    logic [N-1:0]         sel_rs2;
    logic [31:0]          sel_inst;
    logic                 sel_rsp_ready;

    alu_arb_grant u_grant (
        .valid0_i     (ch0.req_valid),
        .valid1_i     (ch1.req_valid),
        .last_grant_i (last_q),
        .any_o        (any_req),
        .grant_o      (gnt_sel)
    );

    assign sel_rs1       = gnt_sel ? ch1.req_rs1  : ch0.req_rs1;
    assign sel_rs2       = gnt_sel ? ch1.req_rs2  : ch0.req_rs2;
    assign sel_inst      = gnt_sel ? ch1.req_inst : ch0.req_inst;
    assign sel_rsp_ready = gnt_q   ? ch1.rsp_ready : ch0.rsp_ready;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        alu_rs1_d  = alu_rs1_q;
        alu_rs2_d  = alu_rs2_q;
        alu_inst_d = alu_inst_q;
        res_d      = res_q;
        zf_d       = zf_q;
        err_d      = err_q;
        req_ready  = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    req_ready[gnt_sel] = 1'b1;
                    gnt_d  = gnt_sel;
                    last_d = gnt_sel;
                    if (is_alu_op(sel_inst)) begin
                        alu_rs1_d  = sel_rs1;
                        alu_rs2_d  = sel_rs2;
                        alu_inst_d = sel_inst;
                        cnt_d      = CntW'(ALU_LAT);
                        state_d    = StBusy;
                    end else begin
                        // Rejected opcodes bypass the ALU entirely.
                        res_d[gnt_sel] = '0;
                        zf_d[gnt_sel]  = ERR_ZF;
                        err_d[gnt_sel] = ERR_FLAG;
                        state_d        = StResp;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    res_d[gnt_q] = alu_res;
                    zf_d[gnt_q]  = alu_zf;
                    err_d[gnt_q] = 1'b0;
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (sel_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            alu_rs1_q  <= '0;
            alu_rs2_q  <= '0;
            alu_inst_q <= '0;
            res_q      <= '0;
            zf_q       <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            alu_rs1_q  <= alu_rs1_d;
            alu_rs2_q  <= alu_rs2_d;
            alu_inst_q <= alu_inst_d;
            res_q      <= res_d;
            zf_q       <= zf_d;
            err_q      <= err_d;
        end
    end

    assign alu_rs1  = alu_rs1_q;
    assign alu_rs2  = alu_rs2_q;
    assign alu_inst = alu_inst_q;

    assign ch0.req_ready = req_ready[0];
    assign ch1.req_ready = req_ready[1];
    assign ch0.rsp_valid = (state_q == StResp) && !gnt_q;
    assign ch1.rsp_valid = (state_q == StResp) && gnt_q;
    assign ch0.rsp_res   = res_q[0];
    assign ch1.rsp_res   = res_q[1];
    assign ch0.rsp_zf    = zf_q[0];
    assign ch1.rsp_zf    = zf_q[1];
    assign ch0.rsp_err   = err_q[0];
    assign ch1.rsp_err   = err_q[1];

endmodule
